// File: rtl/accum_sequencer_if.sv
// Accumulator buffer port bundle: one read port (data returned a cycle after the strobe)
// and one write port, each two 32-bit columns wide.
interface accum_sequencer_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              acc_rd_en;
    logic [ADDR_W-1:0] acc_rd_addr;
    logic [31:0]       acc_rd_data0;
    logic [31:0]       acc_rd_data1;
    logic              acc_wr_en;
    logic [ADDR_W-1:0] acc_wr_addr;
    logic [31:0]       acc_wr_data0;
    logic [31:0]       acc_wr_data1;

    modport master (
        output acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data0, acc_wr_data1,
        input  acc_rd_data0, acc_rd_data1
    );

    modport slave (
        input  acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data0, acc_wr_data1,
        output acc_rd_data0, acc_rd_data1
    );
endinterface

// File: rtl/accum_sequencer.sv
// Result-capture sequencer: clears the alignment stage, then streams aligned row pairs into
// the accumulator buffer through a 3-stage overwrite / read-modify-write pipeline.
module accum_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned ROWS_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ROWS_W-1:0] cfg_rows,
    input  logic              cfg_accumulate,
    output logic              align_clear,
    input  logic              aligned_valid,
    input  logic [15:0]       align_col0,
    input  logic [15:0]       align_col1,
    accum_sequencer_if.master acc,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StClear, StCollect, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ROWS_W-1:0] rows_q;
    logic              accum_q;
    logic [ROWS_W-1:0] row_idx_q, row_idx_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              latch_cfg;
    logic              accept;

    // Stage 1 issues the read, stage 2 sees read data, the write register is stage 3.
    logic              s1_valid_q, s2_valid_q;
    logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
    logic [15:0]       s1_col0_q, s1_col1_q, s2_col0_q, s2_col1_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data0_q, wr_data1_q;
    logic [31:0]       wr_data0_d, wr_data1_d;

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        tcnt_d      = tcnt_q;
        latch_cfg   = 1'b0;
        accept      = 1'b0;
        align_clear = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = StClear;
                    latch_cfg = 1'b1;
                    row_idx_d = '0;
                    tcnt_d    = '0;
                end
            end
            StClear: begin
                align_clear = 1'b1;
                state_d     = (rows_q == '0) ? StDone : StCollect;
            end
            StCollect: begin
                if (aligned_valid) begin
                    accept    = 1'b1;
                    row_idx_d = row_idx_q + 1'b1;
                    tcnt_d    = '0;
                    if (row_idx_d == rows_q) state_d = StDrain;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_timeout = 1'b1;
                    state_d     = StDrain;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (!s1_valid_q && !s2_valid_q) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            row_idx_q <= '0;
            tcnt_q    <= '0;
            base_q    <= '0;
            rows_q    <= '0;
            accum_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            tcnt_q    <= tcnt_d;
            if (latch_cfg) begin
                base_q  <= cfg_base_addr;
                rows_q  <= cfg_rows;
                accum_q <= cfg_accumulate;
            end
        end
    end

    // Overwrite mode never reads, so the buffer term drops out entirely.
    always_comb begin
        wr_data0_d = {{16{s2_col0_q[15]}}, s2_col0_q};
        wr_data1_d = {{16{s2_col1_q[15]}}, s2_col1_q};
        if (accum_q) begin
            wr_data0_d = acc.acc_rd_data0 + wr_data0_d;
            wr_data1_d = acc.acc_rd_data1 + wr_data1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_col0_q  <= '0;
            s1_col1_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_col0_q  <= '0;
            s2_col1_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data0_q <= '0;
            wr_data1_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_addr_q <= base_q + ADDR_W'(row_idx_q);
                s1_col0_q <= align_col0;
                s1_col1_q <= align_col1;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_addr_q <= s1_addr_q;
                s2_col0_q <= s1_col0_q;
                s2_col1_q <= s1_col1_q;
            end
            wr_en_q <= s2_valid_q;
            if (s2_valid_q) begin
                wr_addr_q  <= s2_addr_q;
                wr_data0_q <= wr_data0_d;
                wr_data1_q <= wr_data1_d;
            end
        end
    end

    assign acc.acc_rd_en    = s1_valid_q & accum_q;
    assign acc.acc_rd_addr  = s1_addr_q;
    assign acc.acc_wr_en    = wr_en_q;
    assign acc.acc_wr_addr  = wr_addr_q;
    assign acc.acc_wr_data0 = wr_data0_q;
    assign acc.acc_wr_data1 = wr_data1_q;

endmodule
